// File: rtl/t_ff.sv
`default_nettype none
// ============================================================================
// Module      : t_ff
// Description : Single-bit toggle flip-flop with asynchronous active-low reset
//               and a per-instance reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module t_ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,    // active-low, asynchronous
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state: invert when toggle is requested, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (t) begin
      q_d = ~q_q;
    end
  end

  // State register; reset forces the instance value without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/sr_ff_using_tff.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_using_tff
// Description : Bank of WIDTH independent clocked SR flip-flops, each built
//               from a T flip-flop plus SR-to-T toggle derivation. S=R=1
//               holds state. qbar is always the complement of q.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_using_tff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,   // active-low, asynchronous
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] t_d;

  // Toggle only when the request would change the bit: set while clear, or
  // clear while set. S=R=1 never toggles, so the forbidden input holds.
  always_comb begin
    t_d = (s & ~r & ~q) | (r & ~s & q);
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff #(
        .RESET_VAL (RESET_VAL[i])
      ) u_t_ff (
        .clk (clk),
        .rst (rst),
        .t   (t_d[i]),
        .q   (q[i])
      );
    end
  endgenerate

  assign qbar = ~q;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_using_tff.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ff_using_tff
// Description : Self-checking bench: directed 1-bit scenarios plus a random
//               run on a 4-bit instance with reset value 1010.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ff_using_tff;

  logic       clk = 1'b0;
  logic       rst1 = 1'b1;
  logic       rst4 = 1'b1;
  logic [0:0] s1 = '0, r1 = '0, q1, qb1;
  logic [3:0] s4 = '0, r4 = '0, q4, qb4;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       exp1_q[$];
  logic [3:0] exp4_q[$];
  logic       m1;
  logic [3:0] m4;
  logic       e1;
  logic [3:0] e4;

  always #5 clk = ~clk;

  sr_ff_using_tff #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk (clk), .rst (rst1), .s (s1), .r (r1), .q (q1), .qbar (qb1)
  );

  sr_ff_using_tff #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk (clk), .rst (rst4), .s (s4), .r (r4), .q (q4), .qbar (qb4)
  );

  // Truth-table reference: 00 hold, 01 clear, 10 set, 11 hold.
  function automatic logic [3:0] sr_next(input logic [3:0] cur,
                                         input logic [3:0] s,
                                         input logic [3:0] r);
    logic [3:0] n;
    for (int b = 0; b < 4; b++) begin
      case ({s[b], r[b]})
        2'b01:   n[b] = 1'b0;
        2'b10:   n[b] = 1'b1;
        default: n[b] = cur[b];
      endcase
    end
    return n;
  endfunction

  // Drive one cycle on the 1-bit instance and push the expected q.
  task automatic step1(input logic s, input logic r);
    logic [3:0] n;
    @(negedge clk);
    s1 = s;
    r1 = r;
    n  = sr_next({3'b0, m1}, {3'b0, s}, {3'b0, r});
    m1 = n[0];
    exp1_q.push_back(m1);
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the 4-bit instance and push the expected q.
  task automatic step4(input logic [3:0] s, input logic [3:0] r);
    @(negedge clk);
    s4 = s;
    r4 = r;
    m4 = sr_next(m4, s, r);
    exp4_q.push_back(m4);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    rst1 = 1'b0;
    rst4 = 1'b0;
    #1;
    tests_run++;
    if (q1 !== 1'b0 || qb1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_val_1bit: q=%b qbar=%b expected q=0 qbar=1", q1, qb1);
    end
    tests_run++;
    if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
      tests_failed++;
      $display("FAIL reset_val_4bit: q=%b qbar=%b expected q=1010 qbar=0101", q4, qb4);
    end
    #9;
    rst1 = 1'b1;
    rst4 = 1'b1;
    m1 = 1'b0;
    m4 = 4'b1010;
    for (int k = 0; k < 2; k++) begin
      step1(1'b0, 1'b0);
      if (exp1_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL post_reset_hold: scoreboard empty");
      end else begin
        e1 = exp1_q.pop_front();
        tests_run++;
        if (q1 !== e1 || qb1 !== ~e1) begin
          tests_failed++;
          $display("FAIL post_reset_hold: q=%b qbar=%b expected q=%b", q1, qb1, e1);
        end
      end
    end
  endtask

  task automatic test_clear_when_clear();
    step1(1'b0, 1'b1);
    e1 = exp1_q.pop_front();
    tests_run++;
    if (q1 !== e1 || qb1 !== ~e1) begin
      tests_failed++;
      $display("FAIL clear_on_clear: q=%b qbar=%b expected q=%b", q1, qb1, e1);
    end
  endtask

  task automatic test_set_hold();
    for (int k = 0; k < 4; k++) begin
      step1(1'b1, 1'b0);
      e1 = exp1_q.pop_front();
      tests_run++;
      if (q1 !== e1 || qb1 !== ~e1) begin
        tests_failed++;
        $display("FAIL set_hold[%0d]: q=%b qbar=%b expected q=%b", k, q1, qb1, e1);
      end
    end
  endtask

  task automatic test_forbidden();
    for (int k = 0; k < 4; k++) begin
      step1(1'b1, 1'b1);
      e1 = exp1_q.pop_front();
      tests_run++;
      if (q1 !== e1 || qb1 !== ~e1) begin
        tests_failed++;
        $display("FAIL forbidden_from_1[%0d]: q=%b qbar=%b expected q=%b", k, q1, qb1, e1);
      end
    end
    step1(1'b0, 1'b1);
    e1 = exp1_q.pop_front();
    tests_run++;
    if (q1 !== e1 || qb1 !== ~e1) begin
      tests_failed++;
      $display("FAIL clear_from_1: q=%b qbar=%b expected q=%b", q1, qb1, e1);
    end
    for (int k = 0; k < 2; k++) begin
      step1(1'b1, 1'b1);
      e1 = exp1_q.pop_front();
      tests_run++;
      if (q1 !== e1 || qb1 !== ~e1) begin
        tests_failed++;
        $display("FAIL forbidden_from_0[%0d]: q=%b qbar=%b expected q=%b", k, q1, qb1, e1);
      end
    end
  endtask

  task automatic test_async_reset();
    step1(1'b1, 1'b0);
    e1 = exp1_q.pop_front();
    tests_run++;
    if (q1 !== e1) begin
      tests_failed++;
      $display("FAIL async_pre_set: q=%b expected q=%b", q1, e1);
    end
    @(negedge clk);
    s1 = 1'b0;
    r1 = 1'b0;
    #2;
    rst1 = 1'b0;
    #1;
    m1 = 1'b0;
    tests_run++;
    if (q1 !== 1'b0 || qb1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset_midcycle: q=%b qbar=%b expected q=0 qbar=1", q1, qb1);
    end
    #1;
    rst1 = 1'b1;
    step1(1'b1, 1'b0);
    e1 = exp1_q.pop_front();
    tests_run++;
    if (q1 !== e1 || qb1 !== ~e1) begin
      tests_failed++;
      $display("FAIL set_after_release: q=%b qbar=%b expected q=%b", q1, qb1, e1);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        @(negedge clk);
        s4 = '0;
        r4 = '0;
        #2;
        rst4 = 1'b0;
        #1;
        m4 = 4'b1010;
        tests_run++;
        if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
          tests_failed++;
          $display("FAIL random_midrun_reset: q=%b qbar=%b expected q=1010", q4, qb4);
        end
        #1;
        rst4 = 1'b1;
      end
      step4(4'($urandom), 4'($urandom));
      e4 = exp4_q.pop_front();
      tests_run++;
      if (q4 !== e4 || qb4 !== ~q4) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: q=%b qbar=%b expected q=%b", i, q4, qb4, e4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_when_clear();
    test_set_hold();
    test_forbidden();
    test_async_reset();
    test_random();
    tests_run++;
    if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: left %0d/%0d expected 0/0",
               exp1_q.size(), exp4_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_ff_using_tff.md
Name: sr_ff_using_tff

Overview:
- Clocked SR flip-flop built from an internal T flip-flop plus combinational toggle-derivation logic.
- Registered q and complementary qbar; a bank of WIDTH independent bits, default one bit.
- Leaf storage primitive used in control paths and in the team's flip-flop conversion library.

Parameters:
- WIDTH, 1, number of independent SR bits; each bit uses the same-index s/r/q/qbar.
- RESET_VAL, 0 (WIDTH bits), value loaded into q while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- s  input  WIDTH  set request per bit.
- r  input  WIDTH  reset (clear) request per bit.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  bitwise complement of q, always ~q, including during reset.

Behaviour:
- Reset: while rst=0, q=RESET_VAL and qbar=~RESET_VAL immediately, independent of clk. Asynchronous assertion; release is sampled at the next rising clk edge.
- Release: the first rising edge with rst=1 evaluates s/r normally. No extra latency.
- Per bit, toggle enable t = (s & ~r & ~q) | (r & ~s & q).
- On each rising clk edge with rst=1: if t=1 then q <= ~q, else q holds.
- Resulting truth table per bit, sampled at the edge, with the next q taking effect after that edge:
  - s=0, r=0: hold.
  - s=0, r=1: q=0 (clear).
  - s=1, r=0: q=1 (set).
  - s=1, r=1: hold. This is a forbidden input, and the design decision is that the state is preserved; it never toggles and never goes X.
- Set when already 1, or clear when already 0: t=0, q unchanged.
- Latency: one clock edge from s/r to q; qbar follows q combinationally with no extra cycle.
- Reset asserted mid-operation overrides any pending s/r; q is forced immediately.
- Bits are fully independent; there is no cross-bit interaction.
- No X propagation from q feedback after reset: q is always defined once rst has been low.
- Inputs are synchronous to clk; no internal synchronizers.

Decomposition:
- No shared package needed.
- One natural sub-module: t_ff.
  - Ports: clk, rst (async active-low), t, q.
  - Behaviour: toggles on a rising edge when t=1; resets to a per-instance value.
  - Instantiated WIDTH times via generate.
- The SR-to-T conversion logic lives in the top module.

Test Plan:
- Clock period 10 ns. Hold rst=0 for 10 ns with s=0, r=0 -> q=0 and qbar=1 during reset. After release, q stays 0 on the next edges.
- After release, apply s=0, r=1 for one cycle -> q=0, qbar=1 (clear on an already-clear bit, no toggle).
- Apply s=1, r=0 -> q=1, qbar=0 after the next rising edge. Hold s=1, r=0 for 3 more cycles -> q stays 1.
- From q=1, apply s=1, r=1 for 4 cycles -> q stays 1 with no toggling. From q=0, apply s=1, r=1 -> q stays 0.
- From q=1, drive rst=0 between clock edges -> q=0 and qbar=1 immediately, without waiting for an edge. Release and apply s=1, r=0 -> q=1 after the first edge.
- Exhaustive random run of 1000 cycles, with WIDTH=4 and RESET_VAL=4'b1010:
  - Compare against the truth-table model each cycle.
  - Check qbar == ~q every cycle.
  - Check that the reset value is 1010.
